// File: rtl/pacote_processador.sv
// Shared definitions for the instruction fetch slice: word width, reset PC and FIFO entry type.
package pacote_processador;

    localparam int LARGURA_PALAVRA = 32;
    localparam logic [LARGURA_PALAVRA-1:0] PC_INICIAL_PADRAO = 32'h0000_0000;

    // Wide enough to count 0..8 entries or in-flight requests
    localparam int LARGURA_CONTADOR = 4;

    typedef logic [LARGURA_PALAVRA-1:0] palavra_t;

    typedef struct packed {
        palavra_t instrucao;
        palavra_t endereco;
    } entrada_fifo_t;

endpackage

// File: rtl/fifo_instrucao.sv
// Prefetch FIFO holding fetched instructions with their word addresses; supports flush and push+pop when full.
module fifo_instrucao
    import pacote_processador::*;
#(
    parameter int  PROFUNDIDADE = 2,
    parameter type T_ENTRADA    = entrada_fifo_t
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        limpa,
    input  logic                        escreve,
    input  logic                        le,
    input  T_ENTRADA                    dado_escrita,
    output T_ENTRADA                    cabeca,
    output logic                        vazia,
    output logic [LARGURA_CONTADOR-1:0] contagem
);

    localparam int LARG_IDX = $clog2(PROFUNDIDADE);
    localparam logic [LARG_IDX-1:0] ULTIMO = LARG_IDX'(PROFUNDIDADE - 1);
    localparam logic [LARGURA_CONTADOR-1:0] CHEIO = LARGURA_CONTADOR'(PROFUNDIDADE);

    T_ENTRADA               memoria [PROFUNDIDADE];
    logic [LARG_IDX-1:0]    ptr_leitura;
    logic [LARG_IDX-1:0]    ptr_escrita;
    logic                   cheia;
    logic                   escrita_ok;
    logic                   leitura_ok;

    function automatic logic [LARG_IDX-1:0] avanca(input logic [LARG_IDX-1:0] p);
        return (p == ULTIMO) ? '0 : p + 1'b1;
    endfunction

    assign vazia      = (contagem == '0);
    assign cheia      = (contagem == CHEIO);
    assign leitura_ok = le && !vazia;
    assign escrita_ok = escreve && (!cheia || le);
    assign cabeca     = vazia ? '0 : memoria[ptr_leitura];

    // Storage array: written on an accepted push, no reset needed since reads are gated by vazia
    always_ff @(posedge clock) begin
        if (escrita_ok && !limpa) begin
            memoria[ptr_escrita] <= dado_escrita;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            contagem    <= '0;
        end else if (limpa) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            contagem    <= '0;
        end else begin
            if (escrita_ok) begin
                ptr_escrita <= avanca(ptr_escrita);
            end
            if (leitura_ok) begin
                ptr_leitura <= avanca(ptr_leitura);
            end
            contagem <= contagem + LARGURA_CONTADOR'(escrita_ok) - LARGURA_CONTADOR'(leitura_ok);
        end
    end

    // A push into a full FIFO without a matching pop would lose an instruction
    assert property (@(posedge clock) disable iff (!reset_n) !(escreve && !limpa && cheia && !le));

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: word-addressed PC, credit-limited requests, redirect with discard of stale responses.
module busca_instrucao
    import pacote_processador::*;
#(
    parameter int       PROFUNDIDADE = 2,
    parameter palavra_t PC_INICIAL   = PC_INICIAL_PADRAO
) (
    input  logic     clock,
    input  logic     reset_n,
    output logic     mem_req_valid,
    input  logic     mem_req_ready,
    output palavra_t mem_endereco,
    input  logic     mem_resp_valid,
    input  palavra_t mem_resp_dado,
    output palavra_t instrucao,
    output palavra_t endereco,
    output logic     saida_valida,
    input  logic     consome,
    input  logic     desvio,
    input  palavra_t alvo_desvio
);

    localparam logic [LARGURA_CONTADOR:0] LIMITE = (LARGURA_CONTADOR + 1)'(PROFUNDIDADE);

    palavra_t                    pc;
    palavra_t                    endereco_resposta;
    logic                        ativo;
    logic [LARGURA_CONTADOR-1:0] em_voo;
    logic [LARGURA_CONTADOR-1:0] em_voo_prox;
    logic [LARGURA_CONTADOR-1:0] descarte;
    logic [LARGURA_CONTADOR-1:0] fifo_count;
    logic                        aceito;
    logic                        grava;
    logic                        fifo_vazia;
    entrada_fifo_t               entrada;
    entrada_fifo_t               cabeca;

    // Requests only while FIFO slots plus outstanding requests leave room; ativo holds them off until after reset
    assign mem_req_valid = ativo && (({1'b0, fifo_count} + {1'b0, em_voo}) < LIMITE);
    assign mem_endereco  = pc;
    assign aceito        = mem_req_valid && mem_req_ready;
    assign em_voo_prox   = em_voo + LARGURA_CONTADOR'(aceito) - LARGURA_CONTADOR'(mem_resp_valid);

    // Responses are kept only when nothing is pending discard and no redirect happens this cycle
    assign grava = mem_resp_valid && (descarte == '0) && !desvio;

    assign entrada.instrucao = mem_resp_dado;
    assign entrada.endereco  = endereco_resposta;

    assign saida_valida = !fifo_vazia;
    assign instrucao    = cabeca.instrucao;
    assign endereco     = cabeca.endereco;

    // PC, credit and discard bookkeeping; the next kept response always belongs to endereco_resposta
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc                <= PC_INICIAL;
            endereco_resposta <= PC_INICIAL;
            ativo             <= 1'b0;
            em_voo            <= '0;
            descarte          <= '0;
        end else begin
            ativo  <= 1'b1;
            em_voo <= em_voo_prox;
            if (desvio) begin
                pc                <= alvo_desvio;
                endereco_resposta <= alvo_desvio;
                descarte          <= em_voo_prox;
            end else begin
                if (aceito) begin
                    pc <= pc + 32'd1;
                end
                if (grava) begin
                    endereco_resposta <= endereco_resposta + 32'd1;
                end
                if (mem_resp_valid && (descarte != '0)) begin
                    descarte <= descarte - 1'b1;
                end
            end
        end
    end

    fifo_instrucao #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .T_ENTRADA    (entrada_fifo_t)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .limpa        (desvio),
        .escreve      (grava),
        .le           (consome),
        .dado_escrita (entrada),
        .cabeca       (cabeca),
        .vazia        (fifo_vazia),
        .contagem     (fifo_count)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a 1-cycle-latency in-order instruction memory model.
module tb_busca_instrucao;

    logic        clock;
    logic        reset_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_endereco;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_dado;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic        saida_valida;
    logic        consome;
    logic        desvio;
    logic [31:0] alvo_desvio;

    int          avaliadas = 0;
    int          falhas    = 0;
    logic [31:0] fila[$];
    bit          resp_habilitada;

    busca_instrucao #(
        .PROFUNDIDADE (2),
        .PC_INICIAL   (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_endereco   (mem_endereco),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_dado  (mem_resp_dado),
        .instrucao      (instrucao),
        .endereco       (endereco),
        .saida_valida   (saida_valida),
        .consome        (consome),
        .desvio         (desvio),
        .alvo_desvio    (alvo_desvio)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] dado_de(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        avaliadas++;
        assert (obs === esp) else begin
            falhas++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic verifica_bit(input string tag, input logic obs, input logic esp);
        avaliadas++;
        assert (obs === esp) else begin
            falhas++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, esp);
        end
    endtask

    // One clock cycle: record an accepted request, then return the oldest pending one
    task automatic ciclo();
        logic        acc;
        logic [31:0] ender;
        #1;
        acc   = mem_req_valid && mem_req_ready;
        ender = mem_endereco;
        @(posedge clock);
        #1;
        if (acc) fila.push_back(ender);
        if (resp_habilitada && fila.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_dado  = dado_de(fila.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_dado  = '0;
        end
    endtask

    task automatic verifica_reset(input string tag);
        verifica_bit({tag, "_saida_valida"}, saida_valida, 1'b0);
        verifica_bit({tag, "_req_valid"}, mem_req_valid, 1'b0);
        verifica({tag, "_instrucao"}, instrucao, 32'h0);
        verifica({tag, "_endereco"}, endereco, 32'h0);
        verifica({tag, "_mem_endereco"}, mem_endereco, 32'h0);
    endtask

    initial begin
        reset_n         = 1'b0;
        mem_req_ready   = 1'b1;
        mem_resp_valid  = 1'b0;
        mem_resp_dado   = '0;
        consome         = 1'b0;
        desvio          = 1'b0;
        alvo_desvio     = '0;
        resp_habilitada = 1'b1;

        // Reset state and release
        #2;
        verifica_reset("rst");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        verifica_bit("rel_req_off", mem_req_valid, 1'b0);
        ciclo();
        verifica_bit("c1_req", mem_req_valid, 1'b1);
        verifica("c1_addr", mem_endereco, 32'h0);
        ciclo();
        verifica("c2_addr", mem_endereco, 32'h1);
        verifica_bit("c2_saida", saida_valida, 1'b0);
        ciclo();
        verifica_bit("c3_saida", saida_valida, 1'b1);
        verifica("c3_end", endereco, 32'h0);
        verifica("c3_instr", instrucao, dado_de(32'h0));
        verifica_bit("c3_req_off", mem_req_valid, 1'b0);

        // Held consumer: exactly PROFUNDIDADE requests, then one pop frees one credit
        ciclo();
        verifica_bit("c4_req_off", mem_req_valid, 1'b0);
        verifica("c4_addr", mem_endereco, 32'h2);
        ciclo();
        verifica_bit("c5_req_off", mem_req_valid, 1'b0);
        verifica("c5_head", endereco, 32'h0);
        consome = 1'b1;
        ciclo();
        consome = 1'b0;
        verifica("c6_head", endereco, 32'h1);
        verifica("c6_instr", instrucao, dado_de(32'h1));
        verifica_bit("c6_req_on", mem_req_valid, 1'b1);
        ciclo();
        verifica_bit("c7_req_off", mem_req_valid, 1'b0);
        verifica("c7_addr", mem_endereco, 32'h3);
        ciclo();
        verifica("c8_head", endereco, 32'h1);

        // Drain and build two requests in flight, then redirect to 0x40
        consome = 1'b1;
        ciclo();
        resp_habilitada = 1'b0;
        ciclo();
        consome = 1'b0;
        verifica_bit("c10_saida", saida_valida, 1'b0);
        verifica("c10_addr", mem_endereco, 32'h4);
        ciclo();
        verifica_bit("c11_req_off", mem_req_valid, 1'b0);
        desvio      = 1'b1;
        alvo_desvio = 32'h40;
        ciclo();
        desvio = 1'b0;
        verifica_bit("dsv_saida", saida_valida, 1'b0);
        verifica("dsv_addr", mem_endereco, 32'h40);
        resp_habilitada = 1'b1;
        consome         = 1'b1;
        ciclo();
        consome = 1'b0;
        verifica_bit("dsv_vazio_consome", saida_valida, 1'b0);
        ciclo();
        verifica_bit("dsv_drop1", saida_valida, 1'b0);
        verifica_bit("dsv_req", mem_req_valid, 1'b1);
        ciclo();
        verifica_bit("dsv_drop2", saida_valida, 1'b0);
        verifica("dsv_addr41", mem_endereco, 32'h41);
        ciclo();
        verifica_bit("dsv_saida_ok", saida_valida, 1'b1);
        verifica("dsv_end", endereco, 32'h40);
        verifica("dsv_instr", instrucao, dado_de(32'h40));

        // Redirect to the top word while a response arrives the same cycle; PC then wraps to 0
        desvio      = 1'b1;
        alvo_desvio = 32'hFFFF_FFFF;
        ciclo();
        desvio = 1'b0;
        verifica_bit("wrap_saida", saida_valida, 1'b0);
        verifica("wrap_addr", mem_endereco, 32'hFFFF_FFFF);
        verifica_bit("wrap_req", mem_req_valid, 1'b1);
        ciclo();
        verifica("wrap_addr0", mem_endereco, 32'h0);
        ciclo();
        verifica_bit("wrap_saida_ok", saida_valida, 1'b1);
        verifica("wrap_end", endereco, 32'hFFFF_FFFF);
        verifica("wrap_instr", instrucao, dado_de(32'hFFFF_FFFF));
        ciclo();
        verifica("wrap_head", endereco, 32'hFFFF_FFFF);

        // Memory stalls for 5 cycles: address held, order kept afterwards
        consome = 1'b1;
        ciclo();
        mem_req_ready = 1'b0;
        ciclo();
        consome = 1'b0;
        verifica_bit("stall_saida", saida_valida, 1'b0);
        verifica("stall_addr0", mem_endereco, 32'h1);
        verifica_bit("stall_req0", mem_req_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ciclo();
            verifica("stall_addr", mem_endereco, 32'h1);
            verifica_bit("stall_req", mem_req_valid, 1'b1);
        end
        mem_req_ready = 1'b1;
        ciclo();
        verifica("stall_addr2", mem_endereco, 32'h2);
        ciclo();
        verifica_bit("stall_saida_ok", saida_valida, 1'b1);
        verifica("stall_end1", endereco, 32'h1);
        verifica("stall_instr1", instrucao, dado_de(32'h1));
        ciclo();
        verifica("stall_head1", endereco, 32'h1);
        consome = 1'b1;
        ciclo();
        consome = 1'b0;
        verifica("stall_end2", endereco, 32'h2);
        verifica("stall_instr2", instrucao, dado_de(32'h2));
        verifica("stall_addr3", mem_endereco, 32'h3);

        // Mid-stream reset clears outputs at once and fetch restarts at PC_INICIAL
        reset_n = 1'b0;
        fila.delete();
        mem_resp_valid = 1'b0;
        mem_resp_dado  = '0;
        #1;
        verifica_reset("mid_rst");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        verifica_bit("mid_rel_req_off", mem_req_valid, 1'b0);
        ciclo();
        verifica_bit("mid_req", mem_req_valid, 1'b1);
        verifica("mid_addr0", mem_endereco, 32'h0);
        ciclo();
        verifica("mid_addr1", mem_endereco, 32'h1);
        ciclo();
        verifica_bit("mid_saida", saida_valida, 1'b1);
        verifica("mid_end", endereco, 32'h0);
        verifica("mid_instr", instrucao, dado_de(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", avaliadas, falhas);
        $finish;
    end

endmodule
